// File: rtl/fft_r2sdf_bfly_pkg.sv
// fft_r2sdf_bfly_pkg: width helpers shared by the SDF butterfly stage.
package fft_r2sdf_bfly_pkg;

    function automatic int cplx_w(input int w);
        return 2 * w;
    endfunction

    function automatic int idx_w(input int delay);
        return $clog2(delay);
    endfunction

endpackage

// File: rtl/fft_cplx_addsub.sv
// fft_cplx_addsub: combinational complex a+b and a-b, no growth, no saturation.
module fft_cplx_addsub #(
    parameter int W = 26
) (
    input  logic signed [W-1:0] a_re_i,
    input  logic signed [W-1:0] a_im_i,
    input  logic signed [W-1:0] b_re_i,
    input  logic signed [W-1:0] b_im_i,
    output logic signed [W-1:0] sum_re_o,
    output logic signed [W-1:0] sum_im_o,
    output logic signed [W-1:0] dif_re_o,
    output logic signed [W-1:0] dif_im_o
);

    assign sum_re_o = a_re_i + b_re_i;
    assign sum_im_o = a_im_i + b_im_i;
    assign dif_re_o = a_re_i - b_re_i;
    assign dif_im_o = a_im_i - b_im_i;

endmodule

// File: rtl/fft_r2sdf_bfly.sv
// fft_r2sdf_bfly: radix-2 SDF butterfly; drives an external delay line and
// streams sums (second half of each frame) then differences (during the next fill).
module fft_r2sdf_bfly
    import fft_r2sdf_bfly_pkg::*;
#(
    parameter int DATA_WIDTH = 25,
    parameter int DELAY      = 256
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_valid,
    input  logic signed [DATA_WIDTH-1:0]         in_re,
    input  logic signed [DATA_WIDTH-1:0]         in_im,
    input  logic                                 flush,
    output logic                                 sr_ce,
    output logic [cplx_w(DATA_WIDTH+1)-1:0]      sr_di,
    input  logic [cplx_w(DATA_WIDTH+1)-1:0]      sr_do,
    output logic                                 out_valid,
    output logic signed [DATA_WIDTH:0]           out_re,
    output logic signed [DATA_WIDTH:0]           out_im,
    output logic [idx_w(DELAY)-1:0]              out_idx,
    output logic                                 out_diff
);

    localparam int W  = DATA_WIDTH + 1;
    localparam int IW = idx_w(DELAY);

    logic              adv, phase;
    logic signed [W-1:0] x_re, x_im, d_re, d_im;
    logic signed [W-1:0] sum_re, sum_im, dif_re, dif_im;
    logic [IW:0]       cnt_q, cnt_d;
    logic              primed_q, primed_d, valid_q, valid_d, diff_q, diff_d;
    logic signed [W-1:0] re_q, re_d, im_q, im_d;
    logic [IW-1:0]     idx_q, idx_d;

    assign adv   = in_valid | flush;
    assign sr_ce = adv;
    assign phase = cnt_q[IW];
    assign d_re  = sr_do[2*W-1:W];
    assign d_im  = sr_do[W-1:0];
    assign x_re  = in_valid ? {in_re[DATA_WIDTH-1], in_re} : '0;
    assign x_im  = in_valid ? {in_im[DATA_WIDTH-1], in_im} : '0;

    fft_cplx_addsub #(.W(W)) u_addsub (
        .a_re_i   (d_re),
        .a_im_i   (d_im),
        .b_re_i   (x_re),
        .b_im_i   (x_im),
        .sum_re_o (sum_re),
        .sum_im_o (sum_im),
        .dif_re_o (dif_re),
        .dif_im_o (dif_im)
    );

    // Fill phase stores x and emits last frame's differences; butterfly phase stores differences.
    assign sr_di = phase ? {dif_re, dif_im} : {x_re, x_im};

    always_comb begin
        cnt_d    = adv ? cnt_q + 1'b1 : cnt_q;
        primed_d = primed_q | (adv & phase);
        valid_d  = adv & (phase | primed_q);
        re_d     = adv ? (phase ? sum_re : d_re) : re_q;
        im_d     = adv ? (phase ? sum_im : d_im) : im_q;
        idx_d    = adv ? cnt_q[IW-1:0] : idx_q;
        diff_d   = adv ? ~phase : diff_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            re_q     <= '0;
            im_q     <= '0;
            idx_q    <= '0;
            diff_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            re_q     <= re_d;
            im_q     <= im_d;
            idx_q    <= idx_d;
            diff_q   <= diff_d;
        end
    end

    assign out_valid = valid_q;
    assign out_re    = re_q;
    assign out_im    = im_q;
    assign out_idx   = idx_q;
    assign out_diff  = diff_q;

endmodule

// File: tb/tb_fft_r2sdf_bfly.sv
// tb_fft_r2sdf_bfly: scenario tasks against a frame-level butterfly model and a behavioural delay line.
module tb_fft_r2sdf_bfly;

    localparam int DW = 25;
    localparam int D  = 4;
    localparam int W  = DW + 1;
    localparam int IW = 2;
    localparam int EW = 2 * W + IW + 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, flush = 1'b0, scr = 1'b0;
    logic signed [DW-1:0] in_re = '0, in_im = '0;
    logic sr_ce, out_valid, out_diff;
    logic [2*W-1:0] sr_di, sr_do;
    logic signed [W-1:0] out_re, out_im;
    logic [IW-1:0] out_idx;

    int n_chk = 0, n_fail = 0;
    logic signed [DW-1:0] s_re[$], s_im[$];
    logic [EW-1:0] exp_q[$], cap_q[$];
    logic [2*W-1:0] dl [D];

    always #5 clk = ~clk;

    fft_r2sdf_bfly #(.DATA_WIDTH(DW), .DELAY(D)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_re(in_re), .in_im(in_im),
        .flush(flush), .sr_ce(sr_ce), .sr_di(sr_di), .sr_do(sr_do),
        .out_valid(out_valid), .out_re(out_re), .out_im(out_im),
        .out_idx(out_idx), .out_diff(out_diff)
    );

    // Delay line: value read on a pulse is the one written D pulses earlier; never reset.
    assign sr_do = dl[D-1];
    always @(posedge clk) begin
        if (scr) begin
            for (int i = 0; i < D; i++) dl[i] <= {$urandom, $urandom};
        end else if (sr_ce) begin
            for (int i = D - 1; i > 0; i--) dl[i] <= dl[i-1];
            dl[0] <= sr_di;
        end
    end

    always @(negedge clk)
        if (!rst && out_valid) cap_q.push_back({out_re, out_im, out_idx, out_diff});

    function automatic logic [EW-1:0] pk(input int re, input int im, input int idx, input bit d);
        return {W'(re), W'(im), IW'(idx), d};
    endfunction

    // Each complete 2D-sample frame yields D sums then D differences, in order.
    function automatic void build_exp();
        exp_q.delete();
        for (int f = 0; f + 2 * D <= s_re.size(); f += 2 * D) begin
            for (int n = 0; n < D; n++)
                exp_q.push_back(pk(int'(s_re[f+n]) + int'(s_re[f+D+n]), int'(s_im[f+n]) + int'(s_im[f+D+n]), n, 1'b0));
            for (int n = 0; n < D; n++)
                exp_q.push_back(pk(int'(s_re[f+n]) - int'(s_re[f+D+n]), int'(s_im[f+n]) - int'(s_im[f+D+n]), n, 1'b1));
        end
    endfunction

    task automatic cyc(input bit v, input bit f, input int re, input int im);
        in_valid = v;
        flush = f;
        in_re = DW'(re);
        in_im = DW'(im);
        if (v) begin
            s_re.push_back(DW'(re));
            s_im.push_back(DW'(im));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flush = 1'b0;
    endtask

    task automatic flush_n(input int n);
        repeat (n) cyc(1'b0, 1'b1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic start();
        in_valid = 1'b0;
        flush = 1'b0;
        rst = 1'b0;
        #1;
        rst = 1'b1;
        scr = 1'b1;
        @(posedge clk);
        #1;
        scr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s_re.delete();
        s_im.delete();
        cap_q.delete();
    endtask

    task automatic test_reset();
        start();
        n_chk++;
        if ({out_valid, out_re, out_im, out_idx, out_diff, sr_ce} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", {out_valid, out_re, out_im, out_idx, out_diff, sr_ce});
        end
    endtask

    task automatic test_basic();
        logic [EW-1:0] v;
        start();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, i, 0);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL basic_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL basic_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        v = (cap_q.size() > 0) ? cap_q[0] : 'x;
        n_chk++;
        if (v !== pk(6, 0, 0, 1'b0)) begin
            n_fail++;
            $display("FAIL basic_first_sum: got %h expected %h", v, pk(6, 0, 0, 1'b0));
        end
        v = (cap_q.size() > 7) ? cap_q[7] : 'x;
        n_chk++;
        if (v !== pk(-4, 0, 3, 1'b1)) begin
            n_fail++;
            $display("FAIL basic_last_diff: got %h expected %h", v, pk(-4, 0, 3, 1'b1));
        end
    endtask

    task automatic test_gap();
        logic [EW-1:0] last;
        start();
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, i, 0);
        repeat (3) begin
            cyc(1'b0, 1'b0, 0, 0);
            last = (cap_q.size() > 0) ? cap_q[cap_q.size()-1] : 'x;
            n_chk++;
            if (out_valid !== 1'b0 || {out_re, out_im, out_idx, out_diff} !== last) begin
                n_fail++;
                $display("FAIL gap_hold: got valid=%b %h expected valid=0 %h", out_valid, {out_re, out_im, out_idx, out_diff}, last);
            end
        end
        for (int i = 7; i <= 8; i++) cyc(1'b1, 1'b0, i, 0);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL gap_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL gap_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_extremes();
        logic [EW-1:0] v;
        start();
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 16777215, 0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, -16777216, 0);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL ext_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL ext_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
        v = (cap_q.size() > 5) ? cap_q[5] : 'x;
        n_chk++;
        if (v !== pk(33554431, 0, 1, 1'b1)) begin
            n_fail++;
            $display("FAIL ext_max_diff: got %h expected %h", v, pk(33554431, 0, 1, 1'b1));
        end
    endtask

    task automatic test_back_to_back();
        start();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, i, 0);
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, 10 * i, 0);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != 16 || exp_q.size() != 16) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d expected 16", cap_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL b2b_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        start();
        for (int i = 1; i <= 6; i++) cyc(1'b1, 1'b0, i * 3, i);
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({out_valid, out_re, out_im, out_idx, out_diff} !== '0) begin
            n_fail++;
            $display("FAIL rst_async_zero: got %h expected 0", {out_valid, out_re, out_im, out_idx, out_diff});
        end
        @(posedge clk);
        #1;
        n_chk++;
        if ({out_valid, out_re, out_im, out_idx, out_diff} !== '0) begin
            n_fail++;
            $display("FAIL rst_held_zero: got %h expected 0", {out_valid, out_re, out_im, out_idx, out_diff});
        end
        rst = 1'b0;
        s_re.delete();
        s_im.delete();
        cap_q.delete();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, i, 0);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rst_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rst_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    task automatic test_complex();
        logic [EW-1:0] v;
        logic signed [W-1:0] re, im;
        start();
        for (int i = 1; i <= 8; i++) cyc(1'b1, 1'b0, i, -i);
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL cplx_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            v = cap_q[i];
            re = v[EW-1 -: W];
            im = v[EW-1-W -: W];
            n_chk++;
            if (v !== exp_q[i] || im !== -re) begin
                n_fail++;
                $display("FAIL cplx_sample[%0d]: got %h expected %h", i, v, exp_q[i]);
            end
        end
    endtask

    task automatic test_random();
        start();
        for (int n = 0; n < 3 * 2 * D; n++) begin
            if ($urandom_range(3) == 0) cyc(1'b0, 1'b0, 0, 0);
            cyc(1'b1, 1'b0, int'(DW'($urandom)) , int'(DW'($urandom)));
        end
        flush_n(D);
        build_exp();
        n_chk++;
        if (cap_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL rand_count: got %0d expected %0d", cap_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < cap_q.size(); i++) begin
            n_chk++;
            if (cap_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL rand_sample[%0d]: got %h expected %h", i, cap_q[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gap();
        test_extremes();
        test_back_to_back();
        test_reset_midframe();
        test_complex();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_r2sdf_bfly.md
Name: fft_r2sdf_bfly

Overview:
- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming FFT datapath.
- Pairs with a BRAM-backed shift register of length DELAY that serves as its feedback delay line; this block drives the delay line input and consumes its output.
- Emits one complex sample per accepted input: sums (x[n]+x[n+DELAY]) followed by differences (x[n]-x[n+DELAY]).
- Provides the sample index so the downstream twiddle multiplier can address its ROM.

Parameters:
- DATA_WIDTH, 25, signed width of each input component (re, im).
- DELAY, 256, delay-line length and half the butterfly span; must be a power of two ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input sample strobe.
- in_re  in  DATA_WIDTH  input real part, signed.
- in_im  in  DATA_WIDTH  input imaginary part, signed.
- flush  in  1  drains the delay line with zero input; ignored while in_valid=1.
- sr_ce  out  1  delay-line advance strobe.
- sr_di  out  2*(DATA_WIDTH+1)  delay-line write data, {re,im}.
- sr_do  in  2*(DATA_WIDTH+1)  delay-line read data, {re,im}.
- out_valid  out  1  output sample strobe.
- out_re  out  DATA_WIDTH+1  output real part, signed.
- out_im  out  DATA_WIDTH+1  output imaginary part, signed.
- out_idx  out  log2(DELAY)  index of the output sample within its half-frame.
- out_diff  out  1  1 = the output is a difference (twiddle applies); 0 = the output is a sum.

Behaviour:

Delay-line contract:
- sr_do, sampled on any cycle with sr_ce=1, equals the sr_di value presented exactly DELAY sr_ce pulses earlier.
- The integrator sizes the shift-register instance to meet this.

Advance and combinational outputs:
- adv = in_valid | flush; sr_ce = adv (combinational).
- x = in_valid ? sign-extended (in_re, in_im) : 0.
- Widths: all arithmetic is DATA_WIDTH+1 bits signed; no saturation and no scaling.

Counter:
- cnt is log2(DELAY)+1 bits and increments on adv, wrapping naturally.
- phase = MSB of cnt; idx = low bits of cnt.

Phase 0 (fill):
- sr_di = x.
- Output candidate = sr_do, tagged as a difference (out_diff=1).

Phase 1 (butterfly):
- sr_di = sr_do - x.
- Output candidate = sr_do + x, tagged as a sum (out_diff=0).

primed flag:
- Clears on reset.
- Sets on the first adv with phase=1 and stays set.

Output register:
- All outputs except sr_ce/sr_di are registered, with 1-cycle latency from adv.
- out_valid <= adv & (phase | primed).
- out_re/out_im/out_idx/out_diff update only when adv=1 and otherwise hold.

Reset:
- cnt=0, primed=0, out_valid=0, out_re=0, out_im=0, out_idx=0, out_diff=0.
- Reset mid-frame discards the partial frame.
- Stale delay-line contents are suppressed because primed=0 gates phase-0 outputs.

Boundary cases:
- Wrap from phase 1 idx=DELAY-1 to phase 0 idx=0 is seamless; the differences of frame k emit interleaved with the fill of frame k+1.
- in_valid gaps stall everything; there is no bubble on resumption.
- flush for DELAY cycles after the final frame emits the last DELAY differences.
- flush during phase 1 processes zeros as data; it is the caller's duty to flush only at frame boundaries.
- Overflow is impossible: |a±b| fits in DATA_WIDTH+1 bits.

Decomposition:
- Shared fft package holds:
  - complex-sample width helper function (2*(w)).
  - pack/unpack of {re,im}.
  - CLOG2-derived index width for DELAY.
- One sub-module is natural: fft_cplx_addsub (registered-free combinational a+b / a-b on complex operands).
- The counter/phase/primed control stays in the top.

Test Plan:
1. DELAY=4; in_re = 1..8 consecutive, in_im=0, then flush 4 cycles → out_valid only from cycle after input 5. out_re = 6,8,10,12 (out_diff=0, idx 0..3), then -4,-4,-4,-4 (out_diff=1, idx 0..3).
2. Same stimulus with in_valid deasserted for 3 cycles between inputs 6 and 7 → identical output sequence; no out_valid during the gap; outputs held.
3. Extremes, DATA_WIDTH=25: in_re=+max (16777215) for inputs 1–4 and −min (−16777216) for inputs 5–8 → sums −1; differences 33554431 exactly (no wrap).
4. Two back-to-back frames (16 inputs, frame 2 = 10×frame 1), DELAY=4 → frame-1 differences emitted interleaved with frame-2 fill; output count is 16 after 4-cycle flush.
5. Assert rst for 1 cycle after input 6 (async, mid-clock), then send 8 fresh inputs → all outputs zero during reset; no out_valid until the 5th post-reset input; results match scenario 1.
6. Complex data: in_im = −in_re for scenario 1 → out_im = −out_re for every sample.
